icache_fill_unit: RTL

- Miss-handling stage directly downstream of the icache.
- Accepts one block miss at a time from the icache and issues a block read to the L2.
- Collects the 2 returning 16B beats and writes each beat into the icache data array as it arrives; the critical beat is forwarded to fetch in the same cycle it is written.
- After the last beat arrives, writes the tag/valid entry and pulses completion so fetch can replay.

---
 rtl/icache_fill_unit_pkg.sv | 21 ++
 rtl/icache_fill_unit.sv | 112 +++++++++++
 2 files changed

// File: rtl/icache_fill_unit_pkg.sv
// Shared types and geometry for the icache miss/fill path.
package icache_fill_unit_pkg;

  localparam int PA_WIDTH                  = 34;
  localparam int ICACHE_BLOCK_OFFSET_WIDTH = 5;
  localparam int ICACHE_INDEX_WIDTH        = 7;
  localparam int ICACHE_TAG_WIDTH          = PA_WIDTH - ICACHE_INDEX_WIDTH - ICACHE_BLOCK_OFFSET_WIDTH;
  localparam int ICACHE_ASSOC              = 2;
  localparam int ICACHE_WAY_WIDTH          = $clog2(ICACHE_ASSOC);
  localparam int ICACHE_FETCH_WIDTH        = 16;
  localparam int ICACHE_BLOCK_SIZE         = 1 << ICACHE_BLOCK_OFFSET_WIDTH;
  localparam int ICACHE_BEATS_PER_BLOCK    = ICACHE_BLOCK_SIZE / ICACHE_FETCH_WIDTH;
  localparam int ICACHE_BEAT_INDEX_WIDTH   = $clog2(ICACHE_BEATS_PER_BLOCK);
  localparam int ICACHE_BEAT_DATA_WIDTH    = ICACHE_FETCH_WIDTH * 8;
  localparam int ICACHE_BLOCK_PA_WIDTH     = PA_WIDTH - ICACHE_BLOCK_OFFSET_WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, TAG} icache_fill_state_t;

  typedef logic [ICACHE_BLOCK_PA_WIDTH-1:0] icache_block_PA_t;

endpackage

// File: rtl/icache_fill_unit.sv
// Icache fill unit: takes one block miss, reads it from L2, writes each
// returning beat into the data array, forwards the critical beat to fetch,
// then installs the tag and signals completion.
module icache_fill_unit
  import icache_fill_unit_pkg::*;
(
  input  logic                                CLK,
  input  logic                                rst,
  input  logic                                miss_valid,
  output logic                                miss_ready,
  input  icache_block_PA_t                    miss_PA_block,
  input  logic [ICACHE_WAY_WIDTH-1:0]         miss_way,
  input  logic [ICACHE_BEAT_INDEX_WIDTH-1:0]  miss_beat,
  output logic                                l2_req_valid,
  input  logic                                l2_req_ready,
  output icache_block_PA_t                    l2_req_PA_block,
  input  logic                                l2_resp_valid,
  input  logic [ICACHE_BEAT_INDEX_WIDTH-1:0]  l2_resp_beat,
  input  logic [ICACHE_BEAT_DATA_WIDTH-1:0]   l2_resp_data,
  output logic                                data_write_valid,
  output logic [ICACHE_INDEX_WIDTH-1:0]       data_write_index,
  output logic [ICACHE_WAY_WIDTH-1:0]         data_write_way,
  output logic [ICACHE_BEAT_INDEX_WIDTH-1:0]  data_write_beat,
  output logic [ICACHE_BEAT_DATA_WIDTH-1:0]   data_write_data,
  output logic                                tag_write_valid,
  output logic [ICACHE_INDEX_WIDTH-1:0]       tag_write_index,
  output logic [ICACHE_WAY_WIDTH-1:0]         tag_write_way,
  output logic [ICACHE_TAG_WIDTH-1:0]         tag_write_tag,
  output logic                                crit_fwd_valid,
  output logic [ICACHE_BEAT_DATA_WIDTH-1:0]   crit_fwd_data,
  output logic                                fill_done,
  output logic                                resp_err
);

  icache_fill_state_t                   state_q, state_d;
  icache_block_PA_t                     block_q;
  logic [ICACHE_WAY_WIDTH-1:0]          way_q;
  logic [ICACHE_BEAT_INDEX_WIDTH-1:0]   crit_q;
  logic [ICACHE_BEATS_PER_BLOCK-1:0]    mask_q, mask_d, beat_bit;
  logic                                 resp_in_wait, dup_beat, accept_miss;

  // Response bookkeeping: which beat arrived and whether it was already seen.
  always_comb begin
    beat_bit     = ICACHE_BEATS_PER_BLOCK'(1) << l2_resp_beat;
    resp_in_wait = l2_resp_valid && (state_q == WAIT);
    dup_beat     = resp_in_wait && |(mask_q & beat_bit);
    mask_d       = resp_in_wait ? (mask_q | beat_bit) : mask_q;
    accept_miss  = (state_q == IDLE) && miss_valid;
  end

  // State register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: the beat arriving this cycle counts toward completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_valid)   state_d = REQ;
      REQ:     if (l2_req_ready) state_d = WAIT;
      WAIT:    if (&mask_d)      state_d = TAG;
      TAG:                       state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Miss fields latch on acceptance; beat mask restarts with each fill.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      block_q <= '0;
      way_q   <= '0;
      crit_q  <= '0;
      mask_q  <= '0;
    end else if (accept_miss) begin
      block_q <= miss_PA_block;
      way_q   <= miss_way;
      crit_q  <= miss_beat;
      mask_q  <= '0;
    end else if (resp_in_wait) begin
      mask_q  <= mask_d;
    end
  end

  // Outputs: control from state, array writes/forward straight from the response.
  // Data buses are zeroed when their valid is low so nothing stale leaks out.
  always_comb begin
    miss_ready       = (state_q == IDLE);
    l2_req_valid     = (state_q == REQ);
    l2_req_PA_block  = block_q;

    data_write_valid = resp_in_wait;
    data_write_index = block_q[ICACHE_INDEX_WIDTH-1:0];
    data_write_way   = way_q;
    data_write_beat  = resp_in_wait ? l2_resp_beat : '0;
    data_write_data  = resp_in_wait ? l2_resp_data : '0;

    // Mask guard keeps the forward to one per fill even if the critical beat repeats.
    crit_fwd_valid   = resp_in_wait && (l2_resp_beat == crit_q) && !dup_beat;
    crit_fwd_data    = crit_fwd_valid ? l2_resp_data : '0;

    tag_write_valid  = (state_q == TAG);
    tag_write_index  = block_q[ICACHE_INDEX_WIDTH-1:0];
    tag_write_way    = way_q;
    tag_write_tag    = block_q[ICACHE_BLOCK_PA_WIDTH-1:ICACHE_INDEX_WIDTH];
    fill_done        = (state_q == TAG);

    resp_err         = l2_resp_valid && ((state_q != WAIT) || dup_beat);
  end

endmodule
